// File: rtl/booth_divider_pkg.sv
// Shared definitions for the booth_divider: FSM states, default widths and
// quotient saturation constants.
package booth_div_pkg;

   localparam int WIDTH = 8;
   localparam int STEPS = 2 * WIDTH;
   localparam int CNT_W = $clog2(STEPS);

   localparam logic [WIDTH-1:0] QMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] QMIN = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FINAL = 2'd2
   } state_e;

endpackage

// File: rtl/booth_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor magnitude, keep the difference when it is non-negative.
module div_step
   import booth_div_pkg::*;
(
   input  logic [WIDTH:0]   rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH:0]   rem_o,
   output logic             q_bit_o
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;

   // rem_i < |divisor| <= 2^(WIDTH-1), so the top bit of rem_i is always
   // clear and the shift never loses information.
   assign shifted = {rem_i[WIDTH-1:0], bit_i};
   assign diff    = {1'b0, shifted} - {2'b00, dvs_i};
   assign q_bit_o = ~diff[WIDTH+1];
   assign rem_o   = q_bit_o ? diff[WIDTH:0] : shifted;

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// quotient truncated toward zero, saturated with an overflow flag.
module booth_divider
   import booth_div_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [STEPS-1:0]   dividend_i,
   input  logic [WIDTH-1:0]   divisor_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [WIDTH-1:0]   quotient_o,
   output logic [WIDTH-1:0]   remainder_o,
   output logic               overflow_o,
   output logic               div_by_zero_o,
   output logic [1:0]         state_o
);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [STEPS-1:0] dvd_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH:0]   rem_q;
   logic [WIDTH-1:0] dvd_lo_q;
   logic             qneg_q;
   logic             rneg_q;
   logic             zero_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] quot_q;
   logic [WIDTH-1:0] remout_q;
   logic             ovf_q;
   logic             dbz_q;

   logic [STEPS-1:0] dvd_abs;
   logic [WIDTH-1:0] dvs_abs;
   logic [WIDTH:0]   step_rem;
   logic             step_q;
   logic             q_fits;
   logic [WIDTH-1:0] q_signed;
   logic [WIDTH-1:0] r_signed;

   assign dvd_abs = dividend_i[STEPS-1] ? -dividend_i : dividend_i;
   assign dvs_abs = divisor_i[WIDTH-1]  ? -divisor_i  : divisor_i;

   div_step u_step (
      .rem_i   (rem_q),
      .bit_i   (dvd_q[STEPS-1]),
      .dvs_i   (dvs_q),
      .rem_o   (step_rem),
      .q_bit_o (step_q)
   );

   // dvd_q shifts the dividend magnitude out at the top while quotient bits
   // enter at the bottom, so after STEPS steps it holds |quotient|.
   assign q_fits   = qneg_q ? (dvd_q <= {{WIDTH{1'b0}}, QMIN})
                            : (dvd_q <= {{WIDTH{1'b0}}, QMAX});
   assign q_signed = qneg_q ? -dvd_q[WIDTH-1:0] : dvd_q[WIDTH-1:0];
   assign r_signed = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         dvd_lo_q <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         zero_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         quot_q   <= '0;
         remout_q <= '0;
         ovf_q    <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  dvd_q    <= dvd_abs;
                  dvs_q    <= dvs_abs;
                  dvd_lo_q <= dividend_i[WIDTH-1:0];
                  qneg_q   <= dividend_i[STEPS-1] ^ divisor_i[WIDTH-1];
                  rneg_q   <= dividend_i[STEPS-1];
                  zero_q   <= (divisor_i == '0);
                  cnt_q    <= '0;
                  rem_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= (divisor_i == '0) ? FINAL : CALC;
               end
            end
            CALC: begin
               rem_q <= step_rem;
               dvd_q <= {dvd_q[STEPS-2:0], step_q};
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(STEPS - 1)) begin
                  state_q <= FINAL;
               end
            end
            FINAL: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= IDLE;
               if (zero_q) begin
                  quot_q   <= '0;
                  remout_q <= dvd_lo_q;
                  ovf_q    <= 1'b0;
                  dbz_q    <= 1'b1;
               end else if (!q_fits) begin
                  quot_q   <= qneg_q ? QMIN : QMAX;
                  remout_q <= '0;
                  ovf_q    <= 1'b1;
                  dbz_q    <= 1'b0;
               end else begin
                  quot_q   <= q_signed;
                  remout_q <= r_signed;
                  ovf_q    <= 1'b0;
                  dbz_q    <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign quotient_o    = quot_q;
   assign remainder_o   = remout_q;
   assign overflow_o    = ovf_q;
   assign div_by_zero_o = dbz_q;
   assign state_o       = state_q;

endmodule
